// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage in-order pipeline
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_en_rd,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             if_busy,
  input  logic             mem_start,
  input  logic             mem_done,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             if_kill,
  output logic             protocol_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t state;
  logic   kill_pend;

  logic mem_wait_now;
  logic redirect_act;
  logic load_use;
  logic kill_pend_next;

  // Hazard classification from inputs and registered state
  always_comb begin
    mem_wait_now = ((state == RUN) && mem_start && !mem_done) ||
                   ((state == MEM_WAIT) && !mem_done);
    redirect_act = !mem_wait_now && ex_redirect && ex_valid;
    load_use     = ex_valid && ex_is_load && ex_en_rd && (ex_rd != 5'd0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    // A redirect while a kill is outstanding keeps it armed for the new target fetch
    kill_pend_next = (redirect_act && if_busy) || (kill_pend && (if_busy || redirect_act));
  end

  // Prioritised stall/flush outputs; reset forces bubbles into IF/ID and ID/EX
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if_kill      = 1'b0;
    if (reset) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      // Returned wrong-path fetch is discarded whatever else is happening
      if_kill = kill_pend && !if_busy;
      if (mem_wait_now) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (redirect_act) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (if_busy) begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
      end else if (if_kill) begin
        flush_if_id = 1'b1;
      end
    end
  end

  // Memory-wait FSM, kill tracking and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      kill_pend    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      kill_pend <= kill_pend_next;
      case (state)
        RUN: begin
          if (mem_start && !mem_done) state <= MEM_WAIT;
          if (mem_done && !mem_start) protocol_err <= 1'b1;
        end
        MEM_WAIT: begin
          if (mem_done) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_pc && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect_act && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_en_rd;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        if_busy;
  logic        mem_start;
  logic        mem_done;
  logic        stall_pc;
  logic        stall_if_id;
  logic        stall_id_ex;
  logic        stall_ex_mem;
  logic        stall_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        if_kill;
  logic        protocol_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_en_rd(ex_en_rd), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .if_busy(if_busy),
    .mem_start(mem_start), .mem_done(mem_done),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .if_kill(if_kill),
    .protocol_err(protocol_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex, if_kill}
  function automatic logic [31:0] ctl();
    return {24'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, if_kill};
  endfunction

  task automatic idle();
    reset = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    ex_en_rd = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; if_busy = 1'b0;
    mem_start = 1'b0; mem_done = 1'b0;
  endtask

  // Advance one cycle: inputs change 1 time unit after the edge, checks follow 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    settle();
    check("reset_ctl", ctl(), 32'b0000_0110);
    step();
    settle();
    check("reset_ctl_edge", ctl(), 32'b0000_0110);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    check("reset_flush_events", flush_events, 32'd0);
    check("reset_protocol_err", protocol_err, 32'd0);

    // Load-use on rs2 = x5
    step(); idle();
    id_valid = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_en_rd = 1'b1; ex_rd = 5'd5;
    settle();
    check("load_use_ctl", ctl(), 32'b1100_0010);
    step(); ex_valid = 1'b0; ex_is_load = 1'b0; settle();
    check("load_use_after", ctl(), 32'd0);
    // Same pattern writing x0
    step(); id_rs2 = 5'd0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; settle();
    check("load_use_x0", ctl(), 32'd0);
    // rs1 matches but rs1 is not read
    step(); id_rs1 = 5'd7; id_rs2 = 5'd3; ex_rd = 5'd7; settle();
    check("load_use_rs1_unused", ctl(), 32'd0);
    step(); id_use_rs1 = 1'b1; settle();
    check("load_use_rs1", ctl(), 32'b1100_0010);
    step(); idle(); settle();
    check("stall_cycles_lu", stall_cycles, 32'd2);

    // Three-cycle memory wait
    step(); mem_start = 1'b1; settle();
    check("mem_wait_c0", ctl(), 32'b1111_1000);
    step(); mem_start = 1'b0; settle();
    check("mem_wait_c1", ctl(), 32'b1111_1000);
    step(); mem_start = 1'b1; settle();
    check("mem_wait_start_ignored", ctl(), 32'b1111_1000);
    step(); mem_start = 1'b0; mem_done = 1'b1; settle();
    check("mem_wait_done", ctl(), 32'd0);
    step(); mem_done = 1'b0; settle();
    check("mem_run_after", ctl(), 32'd0);
    check("stall_cycles_mem", stall_cycles, 32'd5);
    check("mem_no_protocol_err", protocol_err, 32'd0);

    // Zero-wait hit
    step(); mem_start = 1'b1; mem_done = 1'b1; settle();
    check("zero_wait", ctl(), 32'd0);
    step(); mem_start = 1'b0; mem_done = 1'b0; settle();
    check("zero_wait_run", ctl(), 32'd0);
    check("zero_wait_no_err", protocol_err, 32'd0);

    // Redirect with fetch in flight
    step(); ex_valid = 1'b1; ex_redirect = 1'b1; if_busy = 1'b1; settle();
    check("redirect_ctl", ctl(), 32'b0000_0110);
    step(); ex_valid = 1'b0; ex_redirect = 1'b0; settle();
    check("redirect_busy", ctl(), 32'b1000_0100);
    step(); if_busy = 1'b0; settle();
    check("redirect_kill", ctl(), 32'b0000_0101);
    step(); settle();
    check("redirect_kill_clear", ctl(), 32'd0);
    check("flush_events_1", flush_events, 32'd1);
    check("stall_cycles_busy", stall_cycles, 32'd6);

    // Redirect held across a two-cycle memory wait
    step(); ex_valid = 1'b1; ex_redirect = 1'b1; mem_start = 1'b1; settle();
    check("redir_wait_c0", ctl(), 32'b1111_1000);
    step(); mem_start = 1'b0; settle();
    check("redir_wait_c1", ctl(), 32'b1111_1000);
    step(); mem_done = 1'b1; settle();
    check("redir_wait_done", ctl(), 32'b0000_0110);
    step(); idle(); settle();
    check("redir_wait_after", ctl(), 32'd0);
    check("flush_events_2", flush_events, 32'd2);
    check("stall_cycles_rw", stall_cycles, 32'd8);

    // Spurious mem_done sets a sticky error
    step(); mem_done = 1'b1; settle();
    check("spurious_done_ctl", ctl(), 32'd0);
    step(); mem_done = 1'b0; settle();
    check("protocol_err_set", protocol_err, 32'd1);
    step(); step(); settle();
    check("protocol_err_sticky", protocol_err, 32'd1);

    // Reset in the middle of a wait
    step(); mem_start = 1'b1; settle();
    step(); mem_start = 1'b0; settle();
    check("pre_reset_wait", ctl(), 32'b1111_1000);
    step(); reset = 1'b1; settle();
    check("reset_mid_wait", ctl(), 32'b0000_0110);
    step(); reset = 1'b0; settle();
    check("post_reset_ctl", ctl(), 32'd0);
    check("post_reset_err", protocol_err, 32'd0);
    check("post_reset_stall_cycles", stall_cycles, 32'd0);
    check("post_reset_flush_events", flush_events, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline. It drives the stall and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, sequences multi-cycle data-memory accesses through a wait FSM, squashes wrong-path work on EX redirects (including a fetch already in flight), and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_events counters

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a real instruction
ex_is_load  in  1  EX instruction is a load
ex_en_rd  in  1  EX instruction writes rd
ex_rd  in  5  EX destination register
ex_redirect  in  1  EX resolved a taken branch or jump
if_busy  in  1  instruction fetch not yet returned this cycle
mem_start  in  1  one-cycle pulse: MEM stage issued a dmem access
mem_done  in  1  one-cycle pulse: dmem access complete
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
stall_mem_wb  out  1  hold MEM/WB (MEM/WB drops en_rd while held)
flush_if_id  out  1  load bubble into IF/ID
flush_id_ex  out  1  load bubble into ID/EX
if_kill  out  1  discard the fetch data returned this cycle
protocol_err  out  1  sticky: mem_done with no access pending
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1
flush_events  out  CNT_W  saturating count of redirect flushes

Behaviour:
- Outputs are combinational from the inputs and the registered state. State is the FSM, kill_pend, protocol_err and the counters.
- FSM states: RUN, MEM_WAIT. Reset -> RUN.
- mem_wait_now = (RUN & mem_start & ~mem_done) | (MEM_WAIT & ~mem_done).
- RUN -> MEM_WAIT when mem_start & ~mem_done. A zero-wait hit (start and done in the same cycle) causes no stall.
- MEM_WAIT -> RUN on mem_done. mem_start in MEM_WAIT is ignored.
- mem_done in RUN without mem_start sets protocol_err. protocol_err is cleared only by reset.
- Priority, highest first:
  1. mem_wait_now: all five stall_* = 1 and no flush. ex_redirect is not acted on, because EX is frozen and re-presents it once the access completes.
  2. ex_redirect & ex_valid: flush_if_id = 1, flush_id_ex = 1, no stalls, flush_events += 1. If if_busy is 1 this cycle, set kill_pend.
  3. Load-use: ex_valid & ex_is_load & ex_en_rd & ex_rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)). Response: stall_pc = 1, stall_if_id = 1, flush_id_ex = 1. This lasts exactly one cycle, because the load then moves to MEM.
  4. if_busy: stall_pc = 1, flush_if_id = 1. Downstream stages keep advancing.
  5. Otherwise all stall and flush outputs are 0.
- kill_pend:
  - While kill_pend = 1 and if_busy = 0, the fetch has returned. if_kill = 1, flush_if_id = 1, and kill_pend clears next cycle.
  - A redirect during kill_pend keeps kill_pend set.
  - if_kill is 0 when kill_pend = 0.
- x0 never causes a hazard.
- Counters:
  - stall_cycles increments on every cycle with stall_pc = 1, including reason 1.
  - Both counters saturate at all-ones.
- Reset, in the same cycle and on the following edge:
  - State = RUN, kill_pend = 0, protocol_err = 0, counters = 0.
  - During reset all stall_* = 0, flush_if_id = 1, flush_id_ex = 1, if_kill = 0.
  - Reset mid-MEM_WAIT abandons the wait.

Test Plan:
- Load x5 in EX, ID reads rs2 = x5 with use = 1 -> one cycle of stall_pc = stall_if_id = flush_id_ex = 1, then all 0; same stimulus with rd = x0 -> no stall.
- mem_start at cycle 10, mem_done at cycle 13 -> all stalls = 1 on cycles 10 to 12, 0 on cycle 13, FSM back to RUN; stall_cycles = 3.
- mem_start and mem_done both at cycle 20 -> no stall, FSM stays RUN.
- ex_redirect with if_busy = 1 at cycle 5, if_busy falls at cycle 7 -> flush_if_id = flush_id_ex = 1 at cycle 5; if_kill = flush_if_id = 1 at cycle 7; flush_events = 1.
- ex_redirect held during a 2-cycle MEM_WAIT -> no flush while waiting; flush asserted on the mem_done cycle; flush_events = 1 (not 3).
- mem_done in RUN with no start -> protocol_err = 1 and stays 1 until reset; reset asserted mid-MEM_WAIT -> next cycle state = RUN, no stalls.
